mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Two-channel memory access unit between the core and a single handshaked memory port.
//  Arbitrates instruction fetch vs load/store, generates word-aligned address and byte enables.
//  Sign/zero-extends load data and flags misaligned or timed-out accesses.
//  Supersedes the core's combinational load/store/memoryLength drive with a variable-latency handshake.
// PARAMETERS
//  DATA_WIDTH  32  data/word width in bits; multiple of 8, power of two >= 16
//  ADDR_WIDTH  32  byte address width
//  MAX_WAIT    15  cycles with mem_req high and no mem_ack before abort; valid range 1..255
// PORTS
//  clk            in   1             clock; all logic on rising edge
//  reset          in   1             synchronous, active-high reset
//  if_req         in   1             fetch request (level); accepted when if_ready=1
//  if_addr        in   ADDR_WIDTH    fetch byte address; must be word aligned
//  if_ready       out  1             unit idle and fetch may be accepted this cycle
//  if_valid       out  1             one-cycle pulse: if_rdata/if_error valid
//  if_rdata       out  DATA_WIDTH    fetched word
//  if_error       out  1             misaligned or timeout; qualified by if_valid
//  ls_req         in   1             load/store request (level); accepted when ls_ready=1
//  ls_store       in   1             1 = store, 0 = load
//  ls_unsigned    in   1             load zero-extends when 1, sign-extends when 0
//  ls_length      in   2             0 byte, 1 half, 2 or 3 word
//  ls_addr        in   ADDR_WIDTH    byte address
//  ls_wdata       in   DATA_WIDTH    store data, right-justified
//  ls_ready       out  1             unit idle and ls may be accepted this cycle
//  ls_valid       out  1             one-cycle pulse: load data, store done, or error
//  ls_rdata       out  DATA_WIDTH    extended load data; 0 for stores and errors
//  ls_error       out  1             misaligned or timeout; qualified by ls_valid
//  mem_req        out  1             held high until mem_ack
//  mem_we         out  1             write strobe
//  mem_addr       out  ADDR_WIDTH    word-aligned address; low log2(DATA_WIDTH/8) bits = 0
//  mem_byteEn     out  DATA_WIDTH/8  active byte lanes
//  mem_wdata      out  DATA_WIDTH    store data shifted into lane position
//  mem_ack        in   1             memory completes the transaction this cycle
//  mem_rdata      in   DATA_WIDTH    read word; sampled when mem_ack=1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except if_ready=ls_ready=1; wait counter 0.
//  Reset mid-transaction: returns to IDLE at that edge; no valid pulse is issued; a late mem_ack is ignored.
//  FSM: IDLE -> IF_BUSY | LS_BUSY | ERR_RSP; *_BUSY -> RSP on mem_ack or timeout; RSP/ERR_RSP -> IDLE.
//  Ready: if_ready = ls_ready = (state==IDLE) && !reset. Accepting at edge N raises mem_req at N+1.
//  Arbitration: ls_req has priority; with both requests high, ls is taken and if_req stays pending.
//  Alignment: lane offset off = addr[log2(DATA_WIDTH/8)-1:0].
//    Half requires off[0]=0; word requires off=0. Fetch requires off=0.
//    A misaligned request never asserts mem_req: ERR_RSP; error valid pulse 1 cycle after accept.
//  Byte enables: byte = 1<<off; half = 2'b11<<off; word = all ones.
//  mem_wdata = ls_wdata << (8*off).
//  Load: the selected lane(s) are shifted down and extended per ls_unsigned.
//  ls_length, ls_unsigned, ls_store, off and the address are registered at accept; inputs may change afterwards.
//  Latency: if mem_ack arrives k cycles after mem_req rises (k>=0), valid pulses k+1 cycles after mem_req rises.
//    Minimum request-to-valid latency is 2 cycles.
//  mem_req/mem_we/mem_addr/mem_byteEn/mem_wdata are stable while mem_req=1; all drop to 0 the cycle after ack.
//  Timeout: the counter increments each cycle mem_req=1 && !mem_ack.
//    Reaching MAX_WAIT drops mem_req and gives a valid pulse with error=1 and rdata=0.
//  mem_ack in IDLE/RSP/ERR_RSP is ignored.
//  Only one valid pulse per accepted request; if_valid and ls_valid are never high together.
// TESTING
//  1 Load word addr 0x100, mem acks 0 cycles after req with 0x8000_00F0 -> ls_valid 2 cycles after accept, ls_rdata 0x8000_00F0.
//  2 Signed byte load addr 0x103, mem_rdata 0x8A00_0000 -> mem_addr 0x100, byteEn 4'b1000, ls_rdata 0xFFFF_FF8A; unsigned -> 0x0000_008A.
//  3 Half store addr 0x202, wdata 0x1234 -> mem_we=1, mem_addr 0x200, byteEn 4'b1100, mem_wdata 0x1234_0000; ls_valid with rdata 0.
//  4 if_req and ls_req high together -> ls served first; fetch accepted the cycle after ls_valid, if_valid follows.
//  5 Word load addr 0x101 -> no mem_req, ls_valid+ls_error next cycle; then mem never acks a fetch -> if_error after 15 wait cycles.
//  6 Assert reset while mem_req=1, then mem_ack 1 cycle later -> IDLE, no valid pulse, ready=1 after reset deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Two-channel memory access unit: arbitrates fetch vs load/store onto one handshaked
// memory port, aligns address/byte lanes, extends load data and flags misalignment/timeout.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic                    if_valid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_error,
    input  logic                    ls_req,
    input  logic                    ls_store,
    input  logic                    ls_unsigned,
    input  logic [1:0]              ls_length,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    output logic                    ls_ready,
    output logic                    ls_valid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    ls_error,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_byteEn,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int OFF_WIDTH = $clog2(BE_WIDTH);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_BUSY = 3'd1,
        LS_BUSY = 3'd2,
        RSP     = 3'd3,
        ERR_RSP = 3'd4
    } state_t;

    state_t                  state_r;
    logic [7:0]              waitCnt_r;
    logic [1:0]              lsLen_r;
    logic                    lsUns_r;
    logic                    lsStore_r;
    logic [OFF_WIDTH-1:0]    off_r;
    logic                    ifValid_r, ifError_r, lsValid_r, lsError_r;
    logic [DATA_WIDTH-1:0]   ifRdata_r, lsRdata_r;
    logic                    memReq_r, memWe_r;
    logic [ADDR_WIDTH-1:0]   memAddr_r;
    logic [BE_WIDTH-1:0]     memByteEn_r;
    logic [DATA_WIDTH-1:0]   memWdata_r;

    logic [OFF_WIDTH-1:0]    lsOff_s;
    logic [OFF_WIDTH-1:0]    ifOff_s;
    logic                    lsMisaligned_s;
    logic                    ifMisaligned_s;

    function automatic logic isMisaligned(input logic [OFF_WIDTH-1:0] off, input logic [1:0] len);
        logic bad;
        case (len)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            default: bad = (off != '0);
        endcase
        return bad;
    endfunction

    function automatic logic [BE_WIDTH-1:0] laneEnables(input logic [OFF_WIDTH-1:0] off, input logic [1:0] len);
        logic [BE_WIDTH-1:0] be;
        case (len)
            2'd0:    be = BE_WIDTH'(1'b1) << off;
            2'd1:    be = BE_WIDTH'(2'b11) << off;
            default: be = '1;
        endcase
        return be;
    endfunction

    // Shift the addressed lane(s) down, then fill the upper bits with zero or the sign bit.
    function automatic logic [DATA_WIDTH-1:0] extendLoad(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [OFF_WIDTH-1:0]  off,
                                                         input logic [1:0]            len,
                                                         input logic                  uns);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] mask;
        logic                  sign;
        sh = word >> {off, 3'b000};
        case (len)
            2'd0: begin
                mask = DATA_WIDTH'(8'hFF);
                sign = sh[7];
            end
            2'd1: begin
                mask = DATA_WIDTH'(16'hFFFF);
                sign = sh[15];
            end
            default: begin
                mask = '1;
                sign = 1'b0;
            end
        endcase
        return (sh & mask) | ((sign & ~uns) ? ~mask : '0);
    endfunction

    assign lsOff_s        = ls_addr[OFF_WIDTH-1:0];
    assign ifOff_s        = if_addr[OFF_WIDTH-1:0];
    assign lsMisaligned_s = isMisaligned(lsOff_s, ls_length);
    assign ifMisaligned_s = (ifOff_s != '0);

    assign if_ready   = (state_r == IDLE) && !reset;
    assign ls_ready   = (state_r == IDLE) && !reset;
    assign if_valid   = ifValid_r;
    assign if_rdata   = ifRdata_r;
    assign if_error   = ifError_r;
    assign ls_valid   = lsValid_r;
    assign ls_rdata   = lsRdata_r;
    assign ls_error   = lsError_r;
    assign mem_req    = memReq_r;
    assign mem_we     = memWe_r;
    assign mem_addr   = memAddr_r;
    assign mem_byteEn = memByteEn_r;
    assign mem_wdata  = memWdata_r;

    // Control FSM with all port-facing outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            waitCnt_r   <= 8'd0;
            lsLen_r     <= 2'd0;
            lsUns_r     <= 1'b0;
            lsStore_r   <= 1'b0;
            off_r       <= '0;
            ifValid_r   <= 1'b0;
            ifError_r   <= 1'b0;
            ifRdata_r   <= '0;
            lsValid_r   <= 1'b0;
            lsError_r   <= 1'b0;
            lsRdata_r   <= '0;
            memReq_r    <= 1'b0;
            memWe_r     <= 1'b0;
            memAddr_r   <= '0;
            memByteEn_r <= '0;
            memWdata_r  <= '0;
        end else begin
            ifValid_r <= 1'b0;
            lsValid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ls_req) begin
                        lsLen_r   <= ls_length;
                        lsUns_r   <= ls_unsigned;
                        lsStore_r <= ls_store;
                        off_r     <= lsOff_s;
                        if (lsMisaligned_s) begin
                            state_r   <= ERR_RSP;
                            lsValid_r <= 1'b1;
                            lsError_r <= 1'b1;
                            lsRdata_r <= '0;
                        end else begin
                            state_r     <= LS_BUSY;
                            memReq_r    <= 1'b1;
                            memWe_r     <= ls_store;
                            memAddr_r   <= {ls_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
                            memByteEn_r <= laneEnables(lsOff_s, ls_length);
                            memWdata_r  <= ls_wdata << {lsOff_s, 3'b000};
                        end
                    end else if (if_req) begin
                        if (ifMisaligned_s) begin
                            state_r   <= ERR_RSP;
                            ifValid_r <= 1'b1;
                            ifError_r <= 1'b1;
                            ifRdata_r <= '0;
                        end else begin
                            state_r     <= IF_BUSY;
                            memReq_r    <= 1'b1;
                            memWe_r     <= 1'b0;
                            memAddr_r   <= {if_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
                            memByteEn_r <= '1;
                            memWdata_r  <= '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IF_BUSY, LS_BUSY: begin
                    if (mem_ack || (waitCnt_r == WAIT_LAST)) begin
                        state_r     <= RSP;
                        waitCnt_r   <= 8'd0;
                        memReq_r    <= 1'b0;
                        memWe_r     <= 1'b0;
                        memAddr_r   <= '0;
                        memByteEn_r <= '0;
                        memWdata_r  <= '0;
                        // Timeout is the only way here without an ack.
                        if (state_r == LS_BUSY) begin
                            lsValid_r <= 1'b1;
                            lsError_r <= !mem_ack;
                            lsRdata_r <= (!mem_ack || lsStore_r) ? '0
                                         : extendLoad(mem_rdata, off_r, lsLen_r, lsUns_r);
                        end else begin
                            ifValid_r <= 1'b1;
                            ifError_r <= !mem_ack;
                            ifRdata_r <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        waitCnt_r <= waitCnt_r + 8'd1;
                    end
                end
                RSP, ERR_RSP: begin
                    state_r   <= IDLE;
                    ifError_r <= 1'b0;
                    ifRdata_r <= '0;
                    lsError_r <= 1'b0;
                    lsRdata_r <= '0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, arbitration,
// misalignment, timeout, wait-state latency and reset during a transaction.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready, if_valid, if_error;
    logic [31:0] if_rdata;
    logic        ls_req, ls_store, ls_unsigned;
    logic [1:0]  ls_length;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready, ls_valid, ls_error;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteEn;

    int vectors;
    int miscompares;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_error(if_error),
        .ls_req(ls_req), .ls_store(ls_store), .ls_unsigned(ls_unsigned), .ls_length(ls_length),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_valid(ls_valid),
        .ls_rdata(ls_rdata), .ls_error(ls_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteEn(mem_byteEn),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load vectors: address, length, unsigned, memory word, expected word address, lanes, result
    logic [31:0] ldAddr [7] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h104};
    logic [1:0]  ldLen  [7] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    logic        ldUns  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ldMem  [7] = '{32'h8000_00F0, 32'h8A00_0000, 32'h8A00_0000, 32'hBEEF_1234,
                                32'hBEEF_1234, 32'h0000_7F00, 32'h1234_8001};
    logic [31:0] ldWAddr[7] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
    logic [3:0]  ldBe   [7] = '{4'hF, 4'h8, 4'h8, 4'hC, 4'hC, 4'h2, 4'h3};
    logic [31:0] ldExp  [7] = '{32'h8000_00F0, 32'hFFFF_FF8A, 32'h0000_008A, 32'hFFFF_BEEF,
                                32'h0000_BEEF, 32'h0000_007F, 32'hFFFF_8001};

    // Store vectors: address, length, data, expected word address, lanes, lane-shifted data
    logic [31:0] stAddr [4] = '{32'h202, 32'h201, 32'h204, 32'h203};
    logic [1:0]  stLen  [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
    logic [31:0] stData [4] = '{32'h0000_1234, 32'h0000_00AB, 32'hDEAD_BEEF, 32'hFFFF_FF55};
    logic [31:0] stWAddr[4] = '{32'h200, 32'h200, 32'h204, 32'h200};
    logic [3:0]  stBe   [4] = '{4'hC, 4'h2, 4'hF, 4'h8};
    logic [31:0] stExp  [4] = '{32'h1234_0000, 32'h0000_AB00, 32'hDEAD_BEEF, 32'h5500_0000};

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_store = 1'b0;
        ls_unsigned = 1'b0; ls_length = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        vectors++; if (ls_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_held: got %b want 0", ls_ready); end
        reset = 1'b0;
        #1;
        vectors++; if ({if_ready, ls_ready} !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b want 11", {if_ready, ls_ready}); end
        vectors++; if ({if_valid, ls_valid, mem_req, mem_we} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {if_valid, ls_valid, mem_req, mem_we}); end
        vectors++; if ({mem_addr, mem_byteEn, mem_wdata, ls_rdata} !== 100'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_byteEn, mem_wdata, ls_rdata}); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ls_req = 1'b1; ls_store = 1'b0; ls_length = ldLen[i]; ls_unsigned = ldUns[i]; ls_addr = ldAddr[i];
            @(negedge clk);
            ls_req = 1'b0; ls_addr = 32'hFFFF_FFFF; ls_length = 2'd3; ls_unsigned = ~ldUns[i];
            vectors++; if ({mem_req, mem_we} !== 2'b10) begin miscompares++; $display("FAIL load_req[%0d]: got %b want 10", i, {mem_req, mem_we}); end
            vectors++; if (mem_addr !== ldWAddr[i]) begin miscompares++; $display("FAIL load_addr[%0d]: got %h want %h", i, mem_addr, ldWAddr[i]); end
            vectors++; if (mem_byteEn !== ldBe[i]) begin miscompares++; $display("FAIL load_be[%0d]: got %b want %b", i, mem_byteEn, ldBe[i]); end
            mem_ack = 1'b1; mem_rdata = ldMem[i];
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
            vectors++; if ({ls_valid, ls_error, if_valid, mem_req} !== 4'b1000) begin miscompares++; $display("FAIL load_valid[%0d]: got %b want 1000", i, {ls_valid, ls_error, if_valid, mem_req}); end
            vectors++; if (ls_rdata !== ldExp[i]) begin miscompares++; $display("FAIL load_data[%0d]: got %h want %h", i, ls_rdata, ldExp[i]); end
            @(negedge clk);
            vectors++; if ({ls_valid, ls_ready} !== 2'b01) begin miscompares++; $display("FAIL load_done[%0d]: got %b want 01", i, {ls_valid, ls_ready}); end
        end
    endtask

    task automatic test_store();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ls_req = 1'b1; ls_store = 1'b1; ls_length = stLen[i]; ls_addr = stAddr[i]; ls_wdata = stData[i];
            @(negedge clk);
            ls_req = 1'b0; ls_store = 1'b0; ls_wdata = 32'h0;
            vectors++; if ({mem_req, mem_we} !== 2'b11) begin miscompares++; $display("FAIL store_req[%0d]: got %b want 11", i, {mem_req, mem_we}); end
            vectors++; if (mem_addr !== stWAddr[i]) begin miscompares++; $display("FAIL store_addr[%0d]: got %h want %h", i, mem_addr, stWAddr[i]); end
            vectors++; if (mem_byteEn !== stBe[i]) begin miscompares++; $display("FAIL store_be[%0d]: got %b want %b", i, mem_byteEn, stBe[i]); end
            vectors++; if (mem_wdata !== stExp[i]) begin miscompares++; $display("FAIL store_wdata[%0d]: got %h want %h", i, mem_wdata, stExp[i]); end
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            mem_ack = 1'b0;
            vectors++; if ({ls_valid, ls_error, ls_rdata} !== {2'b10, 32'h0}) begin miscompares++; $display("FAIL store_rsp[%0d]: got %b/%h want 10/0", i, {ls_valid, ls_error}, ls_rdata); end
            vectors++; if ({mem_req, mem_we, mem_byteEn, mem_wdata} !== 38'd0) begin miscompares++; $display("FAIL store_drop[%0d]: got %h want 0", i, {mem_req, mem_we, mem_byteEn, mem_wdata}); end
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        ls_req = 1'b1; ls_store = 1'b0; ls_length = 2'd2; ls_unsigned = 1'b0; ls_addr = 32'h0000_0A08;
        @(negedge clk);
        ls_req = 1'b0; ls_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            vectors++; if ({mem_req, mem_addr, ls_valid} !== {1'b1, 32'h0000_0A08, 1'b0}) begin miscompares++; $display("FAIL wait_hold[%0d]: got %b/%h/%b want 1/a08/0", c, mem_req, mem_addr, ls_valid); end
            if (c == 2) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        vectors++; if ({ls_valid, ls_rdata} !== {1'b1, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL wait_valid: got %b/%h want 1/cafef00d", ls_valid, ls_rdata); end
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        ls_req = 1'b1; ls_store = 1'b0; ls_length = 2'd2; ls_addr = 32'h300; if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        ls_req = 1'b0;
        vectors++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin miscompares++; $display("FAIL arb_ls_first: got %b/%h want 1/300", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        vectors++; if ({ls_valid, if_valid, mem_req} !== 3'b100) begin miscompares++; $display("FAIL arb_ls_valid: got %b want 100", {ls_valid, if_valid, mem_req}); end
        @(negedge clk);
        vectors++; if ({if_ready, mem_req, ls_valid} !== 3'b100) begin miscompares++; $display("FAIL arb_if_ready: got %b want 100", {if_ready, mem_req, ls_valid}); end
        @(negedge clk);
        if_req = 1'b0;
        vectors++; if ({mem_req, mem_we, mem_addr, mem_byteEn} !== {2'b10, 32'h400, 4'hF}) begin miscompares++; $display("FAIL arb_if_req: got %b/%h/%b want 10/400/1111", {mem_req, mem_we}, mem_addr, mem_byteEn); end
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        vectors++; if ({if_valid, if_error, ls_valid, if_rdata} !== {3'b100, 32'h2222_2222}) begin miscompares++; $display("FAIL arb_if_valid: got %b/%h want 100/22222222", {if_valid, if_error, ls_valid}, if_rdata); end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h202};
        logic [1:0]  lens  [3] = '{2'd2, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin ls_req = 1'b1; ls_store = 1'b0; ls_length = lens[i]; ls_addr = addrs[i]; end
            else begin if_req = 1'b1; if_addr = addrs[i]; end
            @(negedge clk);
            ls_req = 1'b0; if_req = 1'b0;
            vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mis_noreq[%0d]: got %b want 0", i, mem_req); end
            if (i < 2) begin
                vectors++; if ({ls_valid, ls_error, if_valid, ls_rdata} !== {3'b110, 32'h0}) begin miscompares++; $display("FAIL mis_ls[%0d]: got %b/%h want 110/0", i, {ls_valid, ls_error, if_valid}, ls_rdata); end
            end else begin
                vectors++; if ({if_valid, if_error, ls_valid} !== 3'b110) begin miscompares++; $display("FAIL mis_if[%0d]: got %b want 110", i, {if_valid, if_error, ls_valid}); end
            end
            @(negedge clk);
            vectors++; if ({ls_valid, if_valid, ls_ready} !== 3'b001) begin miscompares++; $display("FAIL mis_done[%0d]: got %b want 001", i, {ls_valid, if_valid, ls_ready}); end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        logic reqHeld;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        if_req = 1'b0;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL to_req: got %b want 1", mem_req); end
        cnt = 0; reqHeld = 1'b1;
        while (if_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (if_valid !== 1'b1 && mem_req !== 1'b1) reqHeld = 1'b0;
        end
        vectors++; if (cnt != 15) begin miscompares++; $display("FAIL to_cycles: got %0d want 15", cnt); end
        vectors++; if (reqHeld !== 1'b1) begin miscompares++; $display("FAIL to_req_held: got %b want 1", reqHeld); end
        vectors++; if ({if_valid, if_error, mem_req, if_rdata} !== {3'b110, 32'h0}) begin miscompares++; $display("FAIL to_rsp: got %b/%h want 110/0", {if_valid, if_error, mem_req}, if_rdata); end
        @(negedge clk);
        vectors++; if ({if_valid, if_ready} !== 2'b01) begin miscompares++; $display("FAIL to_done: got %b want 01", {if_valid, if_ready}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ls_req = 1'b1; ls_store = 1'b0; ls_length = 2'd2; ls_addr = 32'h600;
        @(negedge clk);
        ls_req = 1'b0;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req: got %b want 1", mem_req); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if ({mem_req, ls_valid, ls_ready} !== 3'b000) begin miscompares++; $display("FAIL rst_mid_abort: got %b want 000", {mem_req, ls_valid, ls_ready}); end
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_ack = 1'b0;
        vectors++; if ({ls_valid, if_valid, mem_req, ls_ready} !== 4'b0001) begin miscompares++; $display("FAIL rst_mid_late_ack: got %b want 0001", {ls_valid, if_valid, mem_req, ls_ready}); end
        @(negedge clk);
        vectors++; if ({ls_valid, if_valid, ls_ready, if_ready} !== 4'b0011) begin miscompares++; $display("FAIL rst_mid_idle: got %b want 0011", {ls_valid, if_valid, ls_ready, if_ready}); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load();
        test_store();
        test_wait_states();
        test_arbitration();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
